tl45_muldiv: RTL and testbench
==============================

# tl45_muldiv

Iterative unsigned multiply/divide sequencer for the TL45 execute stage, issued alongside the single-cycle ALU. It accepts MUL/DIVU/REMU from the decode buffer and runs a 32-step shift-add or restoring-divide loop. While busy it stalls upstream stages, then writes the result to its own output buffer and the operand-forward port. It obeys the pipeline's stall/flush protocol.

## Interface
- WIDTH, 32: operand/result width; the iteration count equals WIDTH.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-low reset (0 = reset).
- i_pipe_stall  in  1  downstream stall request.
- i_pipe_flush  in  1  downstream flush request.
- o_pipe_stall  out  1  stall to upstream: i_pipe_stall OR internal stall.
- o_pipe_flush  out  1  equal to i_pipe_flush (pass-through; this block never originates a flush).
- i_opcode  in  5  MUL=5'h3, DIVU=5'h4, REMU=5'h5; other opcodes are ignored.
- i_dr  in  4  destination register.
- i_sr1_val, i_sr2_val  in  WIDTH  operand A (multiplicand/dividend) and operand B (multiplier/divisor).
- o_dr  out  4  registered destination; 0 means no write.
- o_value  out  WIDTH  registered result.
- o_of_reg  out  4  forward register: the latched dr in DONE, otherwise 0.
- o_of_val  out  WIDTH  forward value: the result in DONE, otherwise 0.
- o_busy  out  1  high in BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE; a 5-bit step counter (log2 WIDTH).
- IDLE accept condition: the opcode is one of MUL/DIVU/REMU, and i_pipe_stall=0, and i_pipe_flush=0.
- On accept:
  - Latch the op, i_dr and both operands; clear the accumulator and the counter.
  - Go to BUSY.
  - Exception: DIVU/REMU with i_sr2_val=0 goes directly to DONE with result 32'hFFFFFFFF (DIVU) or i_sr1_val (REMU).
- IDLE without accept: o_dr<=0, o_value<=0 (unless i_pipe_stall=1, in which case both hold).
- BUSY, one step per cycle:
  - MUL: if mplier[0]=1 then acc += mcand; then mcand <<= 1 and mplier >>= 1.
  - DIVU/REMU (restoring): {rem,quo} <<= 1; if rem >= divisor then rem -= divisor and quo[0] = 1.
  - Leave BUSY when counter = WIDTH-1; go to DONE.
- DONE:
  - Result: MUL gives the low WIDTH bits of the product (overflow discarded); DIVU gives quo; REMU gives rem.
  - If i_pipe_stall=0: o_dr<=latched dr, o_value<=result, go to IDLE.
  - Otherwise hold DONE with outputs unchanged.
- Internal stall is high when:
  - in IDLE with an accept condition, or
  - in BUSY.
- Internal stall is low in DONE, so the upstream stage advances exactly once at the DONE edge.
- Upstream holds the instruction while stalled; this block ignores i_opcode while in BUSY or DONE.
- i_pipe_flush=1 in BUSY or DONE aborts the operation: go to IDLE, o_dr<=0, o_value<=0, and the forward outputs go to 0.
- Flags are not touched (the ALU owns the flag register).

## Timing
- Reset (i_reset=0 at an edge) applies on that edge:
  - state=IDLE, counter=0, acc/rem/quo=0.
  - o_dr=0, o_value=0.
  - o_of_reg=0, o_of_val=0, o_busy=0.
  - o_pipe_stall = i_pipe_stall.
- Reset overrides everything, including mid-BUSY, and discards the operation.
- Accept in cycle T:
  - BUSY during T+1..T+WIDTH; DONE in T+WIDTH+1.
  - o_dr/o_value become valid after the edge ending T+WIDTH+1.
  - o_pipe_stall is high for WIDTH+1 cycles (T..T+WIDTH).
- Divide-by-zero: DONE in T+1 and stall for 1 cycle; the output is registered after the edge ending T+1.
- o_of_* is valid combinationally during DONE, one cycle before o_value.
- Back-to-back ops: the next MUL/DIVU/REMU is accepted no earlier than the first IDLE cycle after DONE; there is no bubble beyond that.
- Simultaneous flush and reset: reset wins. Simultaneous flush and accept condition in IDLE: no accept.
- Counter wrap: none; the counter is cleared on accept and never passes WIDTH-1.

## Test plan
- MUL: 7×6 → o_value=42 and o_dr=i_dr, 34 cycles after issue, stall high 33 cycles. Also 32'hFFFFFFFF×2 → 32'hFFFFFFFE.
- DIVU 100/7 → 14 and REMU 100/7 → 2. Also DIVU 32'h80000000/1 → 32'h80000000.
- DIVU 5/0 → 32'hFFFFFFFF and REMU 5/0 → 5, each with a single-cycle stall and output after 2 cycles.
- Flush asserted on the 10th BUSY cycle of a MUL → IDLE next cycle, o_dr=0, no result. A following ADD-opcode input leaves o_dr=0.
- i_reset=0 mid-DIVU → all outputs 0 next cycle. After release, the new MUL 3×3 → 9 with nominal latency.
- i_pipe_stall held 3 cycles while in DONE → outputs and o_of_* hold, then the write occurs on the first unstalled edge. An ADD opcode issued back-to-back after the MUL produces no write from this block.

Source files
------------

// File: rtl/tl45_muldiv.sv
// rtl/tl45_muldiv.sv - iterative unsigned MUL/DIVU/REMU sequencer for the TL45 execute stage
module tl45_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pipe_stall,
  input  logic             i_pipe_flush,
  output logic             o_pipe_stall,
  output logic             o_pipe_flush,
  input  logic [4:0]       i_opcode,
  input  logic [3:0]       i_dr,
  input  logic [WIDTH-1:0] i_sr1_val,
  input  logic [WIDTH-1:0] i_sr2_val,
  output logic [3:0]       o_dr,
  output logic [WIDTH-1:0] o_value,
  output logic [3:0]       o_of_reg,
  output logic [WIDTH-1:0] o_of_val,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [4:0] OP_MUL  = 5'h3;
  localparam logic [4:0] OP_DIVU = 5'h4;
  localparam logic [4:0] OP_REMU = 5'h5;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [4:0]       op;
  logic [3:0]       dr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;

  logic             is_op;
  logic             accept;
  logic             int_stall;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] result;

  always_comb begin
    is_op  = (i_opcode == OP_MUL) || (i_opcode == OP_DIVU) || (i_opcode == OP_REMU);
    // Reset masks the accept so the stall output follows i_pipe_stall while held in reset.
    accept = i_reset && (state == S_IDLE) && is_op && !i_pipe_stall && !i_pipe_flush;
    int_stall = accept || (state == S_BUSY);

    // Restoring divide step: the shifted partial remainder needs one extra bit for the compare.
    rem_shift = {rem, quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    rem_ge    = (rem_shift >= {1'b0, divisor});
    rem_next  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], rem_ge};

    case (op)
      OP_MUL:  result = acc;
      OP_DIVU: result = quo;
      default: result = rem;
    endcase

    o_pipe_stall = i_pipe_stall || int_stall;
    o_pipe_flush = i_pipe_flush;
    o_busy       = (state != S_IDLE);
    o_of_reg     = (state == S_DONE) ? dr : 4'd0;
    o_of_val     = (state == S_DONE) ? result : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= S_IDLE;
      count   <= '0;
      op      <= 5'd0;
      dr      <= 4'd0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      o_dr    <= 4'd0;
      o_value <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!i_pipe_stall) begin
            o_dr    <= 4'd0;
            o_value <= '0;
          end
          if (accept) begin
            op      <= i_opcode;
            dr      <= i_dr;
            mcand   <= i_sr1_val;
            mplier  <= i_sr2_val;
            divisor <= i_sr2_val;
            acc     <= '0;
            count   <= '0;
            if ((i_opcode != OP_MUL) && (i_sr2_val == '0)) begin
              // Divide by zero skips the loop; both result registers are preloaded.
              quo   <= '1;
              rem   <= i_sr1_val;
              state <= S_DONE;
            end else begin
              quo   <= i_sr1_val;
              rem   <= '0;
              state <= S_BUSY;
            end
          end
        end

        S_BUSY: begin
          if (i_pipe_flush) begin
            o_dr    <= 4'd0;
            o_value <= '0;
            state   <= S_IDLE;
          end else begin
            if (op == OP_MUL) begin
              if (mplier[0]) begin
                acc <= acc + mcand;
              end
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end else begin
              rem <= rem_next;
              quo <= quo_next;
            end
            if (count == LAST_STEP) begin
              state <= S_DONE;
            end else begin
              count <= count + CW'(1);
            end
          end
        end

        S_DONE: begin
          if (i_pipe_flush) begin
            o_dr    <= 4'd0;
            o_value <= '0;
            state   <= S_IDLE;
          end else if (!i_pipe_stall) begin
            o_dr    <= dr;
            o_value <= result;
            state   <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl45_muldiv.sv
// tb/tb_tl45_muldiv.sv - randomized and directed self-checking bench for tl45_muldiv
module tb_tl45_muldiv;

  localparam logic [4:0] OP_MUL  = 5'h3;
  localparam logic [4:0] OP_DIVU = 5'h4;
  localparam logic [4:0] OP_REMU = 5'h5;
  localparam logic [4:0] OP_ADD  = 5'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  opcode = 5'h0;
  logic [3:0]  dr = 4'h0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;

  logic        o_pipe_stall;
  logic        o_pipe_flush;
  logic [3:0]  o_dr;
  logic [31:0] o_value;
  logic [3:0]  o_of_reg;
  logic [31:0] o_of_val;
  logic        o_busy;

  int n_vec = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  // Reference model: mode 0 idle, 1 looping, 2 result ready.
  int          m_mode = 0;
  int          m_left = 0;
  logic [31:0] m_res = 32'h0;
  logic [3:0]  m_rdr = 4'h0;
  logic [3:0]  m_odr = 4'h0;
  logic [31:0] m_oval = 32'h0;

  tl45_muldiv #(.WIDTH(32)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_pipe_stall (stall),
    .i_pipe_flush (flush),
    .o_pipe_stall (o_pipe_stall),
    .o_pipe_flush (o_pipe_flush),
    .i_opcode     (opcode),
    .i_dr         (dr),
    .i_sr1_val    (a),
    .i_sr2_val    (b),
    .o_dr         (o_dr),
    .o_value      (o_value),
    .o_of_reg     (o_of_reg),
    .o_of_val     (o_of_val),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'h0, x} * {32'h0, y};
    if (op == OP_MUL) return p[31:0];
    if (op == OP_DIVU) return (y == 0) ? 32'hFFFF_FFFF : x / y;
    return (y == 0) ? x : x % y;
  endfunction

  function automatic bit model_pstall();
    bit acc_now;
    acc_now = rst && (m_mode == 0) && is_op(opcode) && !stall && !flush;
    return stall || acc_now || (m_mode == 1);
  endfunction

  task automatic model_update();
    if (!rst) begin
      m_mode = 0;
      m_odr  = 4'h0;
      m_oval = 32'h0;
    end else if (m_mode == 0) begin
      if (!stall) begin
        m_odr  = 4'h0;
        m_oval = 32'h0;
      end
      if (is_op(opcode) && !stall && !flush) begin
        m_rdr = dr;
        m_res = ref_result(opcode, a, b);
        if (opcode != OP_MUL && b == 0) m_mode = 2;
        else begin
          m_mode = 1;
          m_left = 32;
        end
      end
    end else if (flush) begin
      m_mode = 0;
      m_odr  = 4'h0;
      m_oval = 32'h0;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end else if (!stall) begin
      m_odr  = m_rdr;
      m_oval = m_res;
      m_mode = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("o_dr", o_dr, m_odr);
        chk("o_value", o_value, m_oval);
        chk("o_busy", o_busy, m_mode != 0);
        chk("o_of_reg", o_of_reg, (m_mode == 2) ? m_rdr : 4'h0);
        chk("o_of_val", o_of_val, (m_mode == 2) ? m_res : 32'h0);
        chk("o_pipe_stall", o_pipe_stall, model_pstall());
        chk("o_pipe_flush", o_pipe_flush, flush);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [3:0] d, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ev, input int elat, input int estall);
    int n;
    int lat;
    logic [31:0] v;
    n = 0;
    lat = -1;
    v = 32'h0;
    opcode = op;
    dr = d;
    a = x;
    b = y;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (o_pipe_stall) n++;
      if (lat < 0 && o_dr == d) begin
        lat = c;
        v = o_value;
      end
      tick();
      if (c == 0) opcode = 5'h0;
    end
    chk("latency", lat, elat);
    chk("stall_cycles", n, estall);
    chk("result", v, ev);
  endtask

  initial begin
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_o_dr", o_dr, 4'h0);
    chk("reset_o_value", o_value, 32'h0);
    chk("reset_o_busy", o_busy, 1'b0);
    rst = 1'b1;
    tick();

    issue(OP_MUL, 4'd3, 32'd7, 32'd6, 32'd42, 34, 33);
    issue(OP_MUL, 4'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 34, 33);
    issue(OP_DIVU, 4'd4, 32'd100, 32'd7, 32'd14, 34, 33);
    issue(OP_REMU, 4'd5, 32'd100, 32'd7, 32'd2, 34, 33);
    issue(OP_DIVU, 4'd6, 32'h8000_0000, 32'd1, 32'h8000_0000, 34, 33);
    issue(OP_DIVU, 4'd7, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1);
    issue(OP_REMU, 4'd8, 32'd5, 32'd0, 32'd5, 2, 1);

    // Flush on the 10th looping cycle of a MUL.
    opcode = OP_MUL; dr = 4'd5; a = 32'd11; b = 32'd13;
    tick();
    opcode = 5'h0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    chk("flush_busy_before", o_busy, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy_after", o_busy, 1'b0);
    chk("flush_o_dr", o_dr, 4'h0);
    opcode = OP_ADD;
    repeat (3) tick();
    chk("add_after_flush_o_dr", o_dr, 4'h0);
    chk("add_after_flush_busy", o_busy, 1'b0);
    opcode = 5'h0;
    tick();

    // Reset in the middle of a divide.
    opcode = OP_DIVU; dr = 4'd9; a = 32'd1000; b = 32'd3;
    tick();
    opcode = 5'h0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("midreset_o_dr", o_dr, 4'h0);
    chk("midreset_o_value", o_value, 32'h0);
    chk("midreset_o_busy", o_busy, 1'b0);
    chk("midreset_o_of_reg", o_of_reg, 4'h0);
    chk("midreset_o_of_val", o_of_val, 32'h0);
    rst = 1'b1;
    tick();
    issue(OP_MUL, 4'd4, 32'd3, 32'd3, 32'd9, 34, 33);

    // Downstream stall held while the result is ready.
    opcode = OP_MUL; dr = 4'd7; a = 32'd5; b = 32'd5;
    tick();
    opcode = 5'h0;
    repeat (32) tick();
    stall = 1'b1;
    #1;
    chk("done_of_reg", o_of_reg, 4'd7);
    chk("done_of_val", o_of_val, 32'd25);
    chk("done_busy", o_busy, 1'b1);
    repeat (3) begin
      tick();
      chk("stall_hold_of_reg", o_of_reg, 4'd7);
      chk("stall_hold_of_val", o_of_val, 32'd25);
      chk("stall_hold_o_dr", o_dr, 4'h0);
    end
    stall = 1'b0;
    tick();
    chk("release_o_dr", o_dr, 4'd7);
    chk("release_o_value", o_value, 32'd25);
    chk("release_busy", o_busy, 1'b0);
    opcode = OP_ADD;
    tick();
    chk("add_after_mul_o_dr", o_dr, 4'h0);
    chk("add_after_mul_busy", o_busy, 1'b0);
    opcode = 5'h0;
    tick();

    // Random traffic with an upstream that advances only when not stalled.
    for (int i = 0; i < 4000; i++) begin
      bit ep;
      ep = model_pstall();
      tick();
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 249) != 0);
      if (!ep) begin
        case ($urandom_range(0, 7))
          0, 3:    opcode = OP_MUL;
          1, 4:    opcode = OP_DIVU;
          2, 7:    opcode = OP_REMU;
          6:       opcode = OP_ADD;
          default: opcode = 5'($urandom_range(0, 31));
        endcase
        dr = 4'($urandom_range(0, 15));
        a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
        case ($urandom_range(0, 7))
          0:       b = 32'h0;
          1, 2:    b = 32'($urandom_range(1, 20));
          default: b = $urandom;
        endcase
      end
    end

    rst = 1'b1; stall = 1'b0; flush = 1'b0; opcode = 5'h0;
    repeat (40) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
